// File: rtl/svm_window_classifier.sv
// svm_window_classifier: final SVM decision stage.
// Adds the trained bias to each completed window score (saturating), compares
// the result to a threshold, tags it with the window coordinates and queues it
// behind a valid/ready output. Total queue capacity is FIFO_DEPTH entries,
// counting the registered head.
module svm_window_classifier #(
  parameter int FEA_I      = 4,
  parameter int FEA_F      = 8,
  parameter int WIN_COLS   = 9,
  parameter int WIN_ROWS   = 13,
  parameter int FIFO_DEPTH = 4,
  localparam int FEA_W = FEA_I + FEA_F,
  localparam int X_W   = (WIN_COLS > 2) ? $clog2(WIN_COLS) : 1,
  localparam int Y_W   = (WIN_ROWS > 2) ? $clog2(WIN_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             i_valid,
  input  logic [FEA_W-1:0] i_score,
  input  logic [FEA_W-1:0] bias,
  input  logic [FEA_W-1:0] threshold,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_det,
  output logic [FEA_W-1:0] o_score,
  output logic [X_W-1:0]   o_win_x,
  output logic [Y_W-1:0]   o_win_y,
  output logic             o_frame_last,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = FEA_W + X_W + Y_W + 2;

  // Window counters and the tag applied to the current sample
  logic [X_W-1:0] cur_x, tag_x, nxt_x;
  logic [Y_W-1:0] cur_y, tag_y, nxt_y;
  logic           tag_last;

  // Tag is (0,0) when frame_start coincides with a sample; next position follows the raster
  always_comb begin
    tag_x    = frame_start ? '0 : cur_x;
    tag_y    = frame_start ? '0 : cur_y;
    tag_last = (tag_x == X_W'(WIN_COLS - 1)) && (tag_y == Y_W'(WIN_ROWS - 1));
    nxt_x    = tag_x + 1'b1;
    nxt_y    = tag_y;
    if (tag_x == X_W'(WIN_COLS - 1)) begin
      nxt_x = '0;
      nxt_y = tag_last ? '0 : tag_y + 1'b1;
    end
  end

  // Counter register: advance per sample, restart on frame_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (i_valid) begin
      cur_x <= nxt_x;
      cur_y <= nxt_y;
    end else if (frame_start) begin
      cur_x <= '0;
      cur_y <= '0;
    end
  end

  // Bias add at one extra bit, then clamp back into the signed FEA_W range
  logic [FEA_W:0]   sum_wide;
  logic [FEA_W-1:0] sum_sat;
  assign sum_wide = {i_score[FEA_W-1], i_score} + {bias[FEA_W-1], bias};

  // Saturate when the two top bits disagree (signed overflow)
  always_comb begin
    sum_sat = sum_wide[FEA_W-1:0];
    if (sum_wide[FEA_W] != sum_wide[FEA_W-1])
      sum_sat = sum_wide[FEA_W] ? {1'b1, {(FEA_W-1){1'b0}}} : {1'b0, {(FEA_W-1){1'b1}}};
  end

  // Stage 1 register: saturated sum plus its window tag
  logic             s1_valid, s1_last;
  logic [FEA_W-1:0] s1_sum;
  logic [X_W-1:0]   s1_x;
  logic [Y_W-1:0]   s1_y;

  // Capture stage-1 data on every accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sum  <= sum_sat;
        s1_x    <= tag_x;
        s1_y    <= tag_y;
        s1_last <= tag_last;
      end
    end
  end

  // Stage 2: decision and FIFO write entry
  logic             s1_det;
  logic [ENT_W-1:0] s1_entry;
  assign s1_det   = $signed(s1_sum) >= $signed(threshold);
  assign s1_entry = {s1_det, s1_sum, s1_x, s1_y, s1_last};

  // FIFO: storage array with a registered read into the output head
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, full, push, drop, mem_empty, load;
  logic [ENT_W-1:0] head;

  assign pop       = o_valid & o_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push      = s1_valid & (~full | pop);
  assign drop      = s1_valid & full & ~pop;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign load      = ~mem_empty & (~o_valid | pop);
  assign head      = mem[rd_ptr[PTR_W-1:0]];

  // Storage write; when storage is full no push can occur, so read/write never collide
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= s1_entry;
  end

  // Pointer, occupancy, output head and sticky overflow management
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      o_valid      <= 1'b0;
      o_det        <= 1'b0;
      o_score      <= '0;
      o_win_x      <= '0;
      o_win_y      <= '0;
      o_frame_last <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr       <= rd_ptr + 1'b1;
        o_valid      <= 1'b1;
        o_det        <= head[ENT_W-1];
        o_score      <= head[ENT_W-2 -: FEA_W];
        o_win_x      <= head[X_W+Y_W : Y_W+1];
        o_win_y      <= head[Y_W:1];
        o_frame_last <= head[0];
      end else if (pop) begin
        o_valid <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop)
        overflow <= 1'b1;
      else if (frame_start)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svm_window_classifier.sv
// tb_svm_window_classifier: directed and randomized checks of the SVM decision
// stage against a queue-based reference model.
module tb_svm_window_classifier;

  localparam int FI = 4, FF = 8, W = FI + FF;
  localparam int COLS = 3, ROWS = 2, DEPTH = 4;
  localparam int NWIN = COLS * ROWS;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_score = '0;
  logic [W-1:0] bias = '0;
  logic [W-1:0] threshold = '0;
  logic         o_valid, o_ready = 1'b0, o_det, o_frame_last, overflow;
  logic [W-1:0] o_score;
  logic [1:0]   o_win_x;
  logic [0:0]   o_win_y;

  svm_window_classifier #(
    .FEA_I(FI), .FEA_F(FF), .WIN_COLS(COLS), .WIN_ROWS(ROWS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .i_valid(i_valid),
    .i_score(i_score), .bias(bias), .threshold(threshold),
    .o_valid(o_valid), .o_ready(o_ready), .o_det(o_det), .o_score(o_score),
    .o_win_x(o_win_x), .o_win_y(o_win_y), .o_frame_last(o_frame_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per result, queue holds everything the block stores
  typedef struct {
    logic         det;
    logic [W-1:0] score;
    int           x;
    int           y;
    logic         last;
    int           enq;
  } res_t;

  res_t q[$];
  res_t s1_item;
  bit   s1_pend = 0;
  int   win_idx = 0;
  bit   ovf = 0;
  bit   exp_vis = 0;
  int   t = 0;

  function automatic res_t make_result(input logic [W-1:0] sc, input int idx);
    res_t r;
    int s;
    s = int'($signed(sc)) + int'($signed(bias));
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    r.score = s[W-1:0];
    r.det   = (s >= int'($signed(threshold)));
    r.x     = idx % COLS;
    r.y     = idx / COLS;
    r.last  = (idx == NWIN - 1);
    r.enq   = 0;
    return r;
  endfunction

  task automatic model_edge(input logic iv, input logic [W-1:0] sc, input logic fs, input bit pop);
    bit drop;
    t++;
    if (pop) begin
      $display("txn t=%0d x=%0d y=%0d last=%0d score=0x%03h det=%0d",
               t, q[0].x, q[0].y, q[0].last, q[0].score, q[0].det);
      void'(q.pop_front());
    end
    drop = 0;
    if (s1_pend) begin
      if (q.size() < DEPTH) begin
        s1_item.enq = t;
        q.push_back(s1_item);
      end else begin
        drop = 1;
      end
    end
    if (fs) ovf = 0;
    if (drop) ovf = 1;
    if (fs) win_idx = 0;
    s1_pend = iv;
    if (iv) begin
      s1_item = make_result(sc, win_idx);
      win_idx = (win_idx + 1) % NWIN;
    end
    exp_vis = (q.size() > 0) && (q[0].enq + 1 <= t);
  endtask

  task automatic compare_outputs();
    check_eq("o_valid", 32'(o_valid), 32'(exp_vis));
    check_eq("overflow", 32'(overflow), 32'(ovf));
    if (exp_vis) begin
      check_eq("o_score", 32'(o_score), 32'(q[0].score));
      check_eq("o_det", 32'(o_det), 32'(q[0].det));
      check_eq("o_win_x", 32'(o_win_x), q[0].x);
      check_eq("o_win_y", 32'(o_win_y), q[0].y);
      check_eq("o_frame_last", 32'(o_frame_last), 32'(q[0].last));
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check 1 time unit later
  task automatic cycle(input logic iv, input logic [W-1:0] sc, input logic fs, input logic rdy);
    bit pop;
    i_valid = iv; i_score = sc; frame_start = fs; o_ready = rdy;
    pop = exp_vis && rdy;
    @(posedge clk);
    model_edge(iv, sc, fs, pop);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, rdy);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic apply_reset();
    i_valid = 0; frame_start = 0; o_ready = 0;
    rst = 1'b1;
    #1;
    q.delete(); s1_pend = 0; win_idx = 0; ovf = 0; exp_vis = 0;
    check_eq("rst_o_valid", 32'(o_valid), 0);
    check_eq("rst_o_det", 32'(o_det), 0);
    check_eq("rst_o_score", 32'(o_score), 0);
    check_eq("rst_o_win_x", 32'(o_win_x), 0);
    check_eq("rst_o_win_y", 32'(o_win_y), 0);
    check_eq("rst_o_frame_last", 32'(o_frame_last), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    apply_reset();

    // Basic detect and two-edge latency
    bias = 12'hF80; threshold = 12'h000;
    cycle(1'b1, 12'h100, 1'b0, 1'b1);
    check_eq("lat_edge1", 32'(o_valid), 0);
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    check_eq("lat_edge2", 32'(o_valid), 0);
    cycle(1'b0, 12'h000, 1'b0, 1'b0);
    check_eq("basic_valid", 32'(o_valid), 1);
    check_eq("basic_score", 32'(o_score), 32'h080);
    check_eq("basic_det", 32'(o_det), 1);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Saturation, positive and negative
    bias = 12'h100;
    cycle(1'b1, 12'h7F0, 1'b0, 1'b1);
    idle(4, 1'b1);
    bias = 12'hF00;
    cycle(1'b1, 12'h800, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Coordinate wrap over 7 samples, then frame_start on the 3rd sample
    bias = 12'h000;
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 12'(i * 37), 1'b0, 1'b1);
    idle(4, 1'b1);
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'(i * 100), (i == 2), 1'b1);
    idle(4, 1'b1);

    // Backpressure: 5 inputs with consumer stalled, 5th dropped
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'(i + 1), 1'b0, 1'b0);
    idle(3, 1'b0);
    check_eq("ovf_set", 32'(overflow), 1);
    idle(6, 1'b1);
    check_eq("ovf_sticky", 32'(overflow), 1);
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    check_eq("ovf_clear", 32'(overflow), 0);

    // Full FIFO with simultaneous pop and push: no drop
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'(16 * i), 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 12'(200 + i), 1'b0, 1'b1);
    idle(8, 1'b1);
    check_eq("full_pop_no_ovf", 32'(overflow), 0);

    // Reset with 3 results queued, next input must be tagged (0,0)
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'(i + 5), 1'b0, 1'b0);
    idle(2, 1'b0);
    apply_reset();
    cycle(1'b1, 12'h040, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic
    bias = 12'($urandom_range(0, 4095));
    threshold = 12'($urandom_range(0, 4095));
    idle(1, 1'b1);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    idle(10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
